// File: rtl/obi_pkg.sv
// OBI request/response channel types shared by every OBI initiator and responder in the system.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_sram_pkg.sv
// Constants and types for the OBI SRAM responder and its optional grant-stall LFSR.
package obi_sram_pkg;

    localparam logic [31:0] OBI_SRAM_OOR_RDATA = 32'hDEADBEEF;

    // Feedback mask for a right-shifting Fibonacci LFSR with taps 16,14,13,11.
    localparam logic [15:0] OBI_SRAM_LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_stage_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & OBI_SRAM_LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/obi_sram_stall_lfsr.sv
// Pseudo-random grant throttle, built only when OBI_SRAM_GNT_STALL_EN is defined.
`ifdef OBI_SRAM_GNT_STALL_EN
module obi_sram_stall_lfsr
    import obi_sram_pkg::*;
#(
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic stall_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule
`endif

// File: rtl/obi_sram_responder.sv
// OBI responder on a single-port word SRAM with a fixed-latency, in-order response pipeline.
// Optional pseudo-random grant stalling is enabled by defining OBI_SRAM_GNT_STALL_EN.
module obi_sram_responder
    import obi_pkg::*;
    import obi_sram_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 1024,
    parameter int unsigned RDATA_LATENCY = 1,
    parameter logic [15:0] STALL_SEED    = 16'hACE1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  req_i,
    output obi_resp_t resp_o
);

    localparam int unsigned AW = $clog2(NUM_WORDS);

    logic          ready_q;
    logic          stall;
    logic          accept;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   rd_data;
    logic [31:0]   mem [NUM_WORDS];
    resp_stage_t   pipe_q [RDATA_LATENCY];

`ifdef OBI_SRAM_GNT_STALL_EN
    obi_sram_stall_lfsr #(
        .STALL_SEED (STALL_SEED)
    ) u_stall_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_o (stall)
    );
`else
    assign stall = 1'b0;
`endif

    assign idx      = req_i.addr[AW+1:2];
    assign in_range = (req_i.addr[31:AW+2] == '0);
    assign accept   = req_i.req & ready_q & ~stall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // NOTE: the SRAM array has no reset; its contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (accept && req_i.we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (req_i.be[i]) begin
                    mem[idx][8*i +: 8] <= req_i.wdata[8*i +: 8];
                end
            end
        end
    end

    // Writes and idle cycles carry zero data down the pipeline.
    always_comb begin
        // NOTE: assigning the default first keeps this block free of inferred latches.
        rd_data = 32'h0;
        if (accept && !req_i.we) begin
            rd_data = in_range ? mem[idx] : OBI_SRAM_OOR_RDATA;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < RDATA_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: accept, data: rd_data};
            for (int k = 1; k < RDATA_LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    always_comb begin
        resp_o        = '0;
        resp_o.gnt    = accept;
        resp_o.rvalid = pipe_q[RDATA_LATENCY-1].valid;
        resp_o.rdata  = pipe_q[RDATA_LATENCY-1].data;
    end

endmodule

// File: tb/tb_obi_sram_responder.sv
// Scoreboard bench for obi_sram_responder: expectations are queued at grant and matched on rvalid.
// Also covers the OBI_SRAM_GNT_STALL_EN build with a golden LFSR grant model.
module tb_obi_sram_responder;
    import obi_pkg::*;

    localparam int          NUM_WORDS = 1024;
    localparam int          AW        = 10;
    localparam int          LAT       = 3;
    localparam logic [15:0] SEED      = 16'hACE1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    obi_req_t  req;
    obi_resp_t resp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        sb [$];
    logic [31:0] model_mem [NUM_WORDS];
    logic        m_ready;
    logic [15:0] m_lfsr;
    logic        m_stall;

    obi_sram_responder #(
        .NUM_WORDS     (NUM_WORDS),
        .RDATA_LATENCY (LAT),
        .STALL_SEED    (SEED)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .resp_o (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden grant model: ready flop plus the taps-16,14,13,11 Fibonacci LFSR.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0;
            m_lfsr  <= SEED;
        end else begin
            m_ready <= 1'b1;
            m_lfsr  <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

`ifdef OBI_SRAM_GNT_STALL_EN
    assign m_stall = (m_lfsr[1:0] == 2'b00);
`else
    assign m_stall = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_gnt", {31'b0, resp.gnt}, 32'h0);
            check("rst_rvalid", {31'b0, resp.rvalid}, 32'h0);
            check("rst_rdata", resp.rdata, 32'h0);
        end else begin
            check("gnt", {31'b0, resp.gnt}, {31'b0, req.req & m_ready & ~m_stall});
            if (resp.rvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", {31'b0, resp.rvalid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", resp.rdata, e.data);
                    check("latency", cyc, e.due);
                end
            end else begin
                check("idle_rdata", resp.rdata, 32'h0);
            end
        end
    end

    // Present one request, hold it until granted, then record the expected response.
    task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int gcyc);
        int          waited = 0;
        logic [31:0] exp;
        logic        in_rng;
        int          idx;
        gcyc      = -1;
        req.req   = 1'b1;
        req.we    = we;
        req.be    = be;
        req.addr  = addr;
        req.wdata = wdata;
        forever begin
            @(negedge clk);
            if (resp.gnt) break;
            waited++;
            if (waited > 64) begin
                check("gnt_timeout", 32'h0, 32'h1);
                break;
            end
        end
        if (resp.gnt) begin
            gcyc   = cyc;
            in_rng = ((addr >> (AW + 2)) == 0);
            idx    = int'(addr[AW+1:2]);
            exp    = 32'h0;
            if (we) begin
                if (in_rng) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end else begin
                exp = in_rng ? model_mem[idx] : 32'hDEADBEEF;
            end
            sb.push_back('{data: exp, due: gcyc + LAT});
        end
        @(posedge clk);
        #1;
        req.req = 1'b0;
    endtask

    initial begin
        int g;
        int prev;
        int rel_cyc;
        int start;
        int i;

        // Reset with a zero-byte-enable write held on the bus.
        req = '{req: 1'b1, we: 1'b1, be: 4'b0000, addr: 32'h0, wdata: 32'h0};
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        xfer(1'b1, 4'b0000, 32'h0, 32'h0, g);
`ifndef OBI_SRAM_GNT_STALL_EN
        check("first_grant_cycle", g, rel_cyc + 1);
`endif

        // Preload words 0..7 with their index.
        for (int w = 0; w < 8; w++) xfer(1'b1, 4'hF, 32'(w * 4), 32'(w), g);

        // Eight back-to-back reads.
        prev = -1;
        for (int w = 0; w < 8; w++) begin
            xfer(1'b0, 4'h0, 32'(w * 4), 32'h0, g);
`ifndef OBI_SRAM_GNT_STALL_EN
            if (w > 0) check("b2b_gap", g - prev, 32'd1);
`endif
            prev = g;
        end

        // Byte-enable merge on word 4.
        xfer(1'b1, 4'b1111, 32'h10, 32'h11223344, g);
        xfer(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, g);
        xfer(1'b0, 4'b0000, 32'h10, 32'h0, g);

        // Read immediately after write on word 5.
        xfer(1'b1, 4'b1111, 32'h14, 32'hCAFEF00D, g);
        prev = g;
        xfer(1'b0, 4'b0000, 32'h14, 32'h0, g);
`ifndef OBI_SRAM_GNT_STALL_EN
        check("raw_gap", g - prev, 32'd1);
`endif

        // Out-of-range write and read, then confirm word 0 is untouched.
        xfer(1'b1, 4'b1111, 32'h1000, 32'h12345678, g);
        xfer(1'b0, 4'b0000, 32'h1000, 32'h0, g);
        xfer(1'b0, 4'b0000, 32'h0, 32'h0, g);

        // Let responses drain before the mid-flight reset.
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("drain_pre_reset", sb.size(), 32'd0);

        // Reset one cycle after a read grant; its response must never appear.
        xfer(1'b0, 4'b0000, 32'hC, 32'h0, g);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // Sustained reads with req held high for about 1000 cycles.
        start = cyc;
        i     = 0;
        while (cyc - start < 1000) begin
            xfer(1'b0, 4'b0000, 32'((i % 8) * 4), 32'h0, g);
            i++;
        end

        for (int n = 0; n < LAT + 8 && sb.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("drain_final", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
